fifo_wr_frontend: RTL and testbench



---
 rtl/fifo_pkg.sv | 32 +++
 rtl/sync_2ff.sv | 24 ++
 rtl/fifo_wr_frontend.sv | 109 ++++++++++
 tb/tb_fifo_wr_frontend.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: write front-end skid states, pointer helpers.
package fifo_pkg;

  localparam int GRAY_MAX_W = 16;

  typedef enum logic [1:0] {
    WFE_EMPTY = 2'd0,
    WFE_ONE   = 2'd1,
    WFE_TWO   = 2'd2
  } wfe_state_t;

  function automatic int fifo_depth(input int ptr_width);
    return 1 << ptr_width;
  endfunction

  // XOR-prefix from the MSB down; bits at or above width come back as 0.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] gray,
                                                     input int width);
    logic [GRAY_MAX_W-1:0] bin;
    logic                  acc;
    bin = '0;
    acc = 1'b0;
    for (int i = GRAY_MAX_W - 1; i >= 0; i--) begin
      if (i < width) begin
        acc    = acc ^ gray[i];
        bin[i] = acc;
      end
    end
    return bin;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for multi-bit Gray-coded values; no logic between stages.
module sync_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;

  // NOTE: sequential state uses non-blocking assignments so both stages sample the pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= '0;
      q      <= '0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/fifo_wr_frontend.sv
// Write-domain front end of the async FIFO: 2-entry skid buffer, read-pointer
// synchronizer and pessimistic write-side fill level.
module fifo_wr_frontend
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int PTR_WIDTH    = 3,
  parameter int AFULL_THRESH = 6
) (
  input  logic                  W_CLK,
  input  logic                  WRST_n,
  input  logic                  S_VALID,
  input  logic [DATA_WIDTH-1:0] S_DATA,
  output logic                  S_READY,
  input  logic [PTR_WIDTH:0]    G_RPTR,
  output logic [PTR_WIDTH:0]    G_RPTR_SYNC,
  input  logic [PTR_WIDTH:0]    B_WPTR,
  input  logic                  FULL,
  output logic                  W_EN,
  output logic [DATA_WIDTH-1:0] W_DATA,
  output logic [PTR_WIDTH:0]    W_LEVEL,
  output logic                  ALMOST_FULL
);

  localparam logic [PTR_WIDTH:0] THRESH = (PTR_WIDTH + 1)'(AFULL_THRESH);

  wfe_state_t            state_q, state_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;
  logic                  accept, pop;
  logic [PTR_WIDTH:0]    b_rptr_sync;
  logic [PTR_WIDTH:0]    level_d;

  assign accept = S_VALID & S_READY;
  assign pop    = (state_q != WFE_EMPTY) & ~FULL;
  assign W_EN   = pop;
  assign W_DATA = head_q;

  // NOTE: every comb output gets a default first, so no path leaves a latch behind.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    unique case (state_q)
      WFE_EMPTY: begin
        if (accept) begin
          state_d = WFE_ONE;
          head_d  = S_DATA;
        end
      end
      WFE_ONE: begin
        if (accept && !pop) begin
          state_d = WFE_TWO;
          skid_d  = S_DATA;
        end else if (!accept && pop) begin
          state_d = WFE_EMPTY;
        end else if (accept && pop) begin
          head_d = S_DATA;
        end
      end
      WFE_TWO: begin
        if (pop) begin
          state_d = WFE_ONE;
          head_d  = skid_q;
        end
      end
      default: state_d = WFE_EMPTY;
    endcase
  end

  // NOTE: the entry registers are reset as well, so W_DATA is 0 rather than stale after reset.
  always_ff @(posedge W_CLK) begin
    if (!WRST_n) begin
      state_q <= WFE_EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
      S_READY <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
      S_READY <= (state_d != WFE_TWO);
    end
  end

  sync_2ff #(
    .WIDTH (PTR_WIDTH + 1)
  ) u_rptr_sync (
    .clk   (W_CLK),
    .rst_n (WRST_n),
    .d     (G_RPTR),
    .q     (G_RPTR_SYNC)
  );

  // Modular subtraction absorbs wrap-around of either pointer.
  assign b_rptr_sync = (PTR_WIDTH + 1)'(gray2bin(GRAY_MAX_W'(G_RPTR_SYNC), PTR_WIDTH + 1));
  assign level_d     = B_WPTR - b_rptr_sync;

  always_ff @(posedge W_CLK) begin
    if (!WRST_n) begin
      W_LEVEL     <= '0;
      ALMOST_FULL <= 1'b0;
    end else begin
      W_LEVEL     <= level_d;
      ALMOST_FULL <= (level_d >= THRESH);
    end
  end

endmodule

// File: tb/tb_fifo_wr_frontend.sv
// Self-checking bench for fifo_wr_frontend: directed stimulus plus a data scoreboard.
module tb_fifo_wr_frontend;

  logic       W_CLK = 1'b0;
  logic       WRST_n;
  logic       S_VALID;
  logic [7:0] S_DATA;
  logic       S_READY;
  logic [3:0] G_RPTR;
  logic [3:0] G_RPTR_SYNC;
  logic [3:0] B_WPTR;
  logic       FULL;
  logic       W_EN;
  logic [7:0] W_DATA;
  logic [3:0] W_LEVEL;
  logic       ALMOST_FULL;

  int checks   = 0;
  int failures = 0;
  int wr_count = 0;
  logic [7:0] sb_q[$];

  fifo_wr_frontend #(
    .DATA_WIDTH   (8),
    .PTR_WIDTH    (3),
    .AFULL_THRESH (6)
  ) dut (
    .W_CLK       (W_CLK),
    .WRST_n      (WRST_n),
    .S_VALID     (S_VALID),
    .S_DATA      (S_DATA),
    .S_READY     (S_READY),
    .G_RPTR      (G_RPTR),
    .G_RPTR_SYNC (G_RPTR_SYNC),
    .B_WPTR      (B_WPTR),
    .FULL        (FULL),
    .W_EN        (W_EN),
    .W_DATA      (W_DATA),
    .W_LEVEL     (W_LEVEL),
    .ALMOST_FULL (ALMOST_FULL)
  );

  always #5 W_CLK = ~W_CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge W_CLK);
    #1;
  endtask

  // Scoreboard: push on handshake, pop and compare on every write to the FIFO.
  always @(negedge W_CLK) begin
    if (!WRST_n) begin
      sb_q.delete();
    end else begin
      if (W_EN === 1'b1) begin
        wr_count++;
        if (sb_q.size() == 0) check("sb_underflow", 32'(W_DATA), 32'hFFFF_FFFF);
        else check("sb_wdata", 32'(W_DATA), 32'(sb_q.pop_front()));
      end
      if (S_VALID === 1'b1 && S_READY === 1'b1) sb_q.push_back(S_DATA);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int wr_base;
    WRST_n  = 1'b0;
    S_VALID = 1'b1;
    S_DATA  = 8'h55;
    G_RPTR  = 4'b0101;
    B_WPTR  = 4'b0000;
    FULL    = 1'b0;
    repeat (3) tick();
    check("rst_s_ready", 32'(S_READY), 0);
    check("rst_w_en", 32'(W_EN), 0);
    check("rst_w_level", 32'(W_LEVEL), 0);
    check("rst_afull", 32'(ALMOST_FULL), 0);
    check("rst_g_rptr_sync", 32'(G_RPTR_SYNC), 0);

    WRST_n  = 1'b1;
    S_VALID = 1'b0;
    G_RPTR  = 4'b0000;
    tick();
    check("rel_s_ready", 32'(S_READY), 1);
    tick();

    // Synchronizer latency: two edges from G_RPTR to G_RPTR_SYNC.
    G_RPTR = 4'b0001;
    tick();
    check("sync_edge_n", 32'(G_RPTR_SYNC), 32'h0);
    tick();
    check("sync_edge_n1", 32'(G_RPTR_SYNC), 32'h1);
    G_RPTR = 4'b0000;
    repeat (3) tick();

    // Streaming at full rate.
    wr_base = wr_count;
    for (int i = 0; i < 8; i++) begin
      S_VALID = 1'b1;
      S_DATA  = 8'(8'h10 + i);
      tick();
      check("stream_ready", 32'(S_READY), 1);
      check("stream_w_en", 32'(W_EN), 1);
      check("stream_w_data", 32'(W_DATA), 32'(8'h10 + i));
    end
    S_VALID = 1'b0;
    tick();
    check("stream_idle_w_en", 32'(W_EN), 0);
    check("stream_wr_count", 32'(wr_count - wr_base), 8);

    // Backpressure while FULL.
    FULL    = 1'b1;
    S_VALID = 1'b1;
    S_DATA  = 8'hA1;
    tick();
    check("bp_ready_one", 32'(S_READY), 1);
    check("bp_w_en_one", 32'(W_EN), 0);
    S_DATA = 8'hA2;
    tick();
    check("bp_ready_two", 32'(S_READY), 0);
    check("bp_w_en_two", 32'(W_EN), 0);
    S_DATA = 8'hA3;
    repeat (2) begin
      tick();
      check("bp_hold_ready", 32'(S_READY), 0);
      check("bp_hold_w_en", 32'(W_EN), 0);
      check("bp_hold_w_data", 32'(W_DATA), 32'hA1);
    end
    FULL = 1'b0;
    #1;
    check("bp_release_w_en", 32'(W_EN), 1);
    check("bp_release_w_data", 32'(W_DATA), 32'hA1);
    tick();
    check("bp_second_w_en", 32'(W_EN), 1);
    check("bp_second_w_data", 32'(W_DATA), 32'hA2);
    check("bp_second_ready", 32'(S_READY), 1);
    tick();
    check("bp_third_w_en", 32'(W_EN), 1);
    check("bp_third_w_data", 32'(W_DATA), 32'hA3);
    S_VALID = 1'b0;
    tick();
    check("bp_drain_w_en", 32'(W_EN), 0);

    // Fill level, threshold and wrap-around.
    B_WPTR = 4'b0110; G_RPTR = 4'b0000;
    repeat (3) tick();
    check("lvl6_level", 32'(W_LEVEL), 6);
    check("lvl6_afull", 32'(ALMOST_FULL), 1);
    B_WPTR = 4'b0010; G_RPTR = 4'b1010;
    repeat (3) tick();
    check("wrap6_level", 32'(W_LEVEL), 6);
    check("wrap6_afull", 32'(ALMOST_FULL), 1);
    B_WPTR = 4'b0101; G_RPTR = 4'b0111;
    repeat (3) tick();
    check("lvl0_level", 32'(W_LEVEL), 0);
    check("lvl0_afull", 32'(ALMOST_FULL), 0);
    B_WPTR = 4'b0101; G_RPTR = 4'b0000;
    repeat (3) tick();
    check("lvl5_level", 32'(W_LEVEL), 5);
    check("lvl5_afull", 32'(ALMOST_FULL), 0);
    B_WPTR = 4'b0011; G_RPTR = 4'b1110;
    repeat (3) tick();
    check("wrap8_level", 32'(W_LEVEL), 8);
    check("wrap8_afull", 32'(ALMOST_FULL), 1);
    B_WPTR = 4'b0000; G_RPTR = 4'b0000;
    repeat (3) tick();

    // Reset while two words are buffered.
    FULL    = 1'b1;
    S_VALID = 1'b1;
    S_DATA  = 8'hC1;
    tick();
    S_DATA = 8'hC2;
    tick();
    check("mid_two_ready", 32'(S_READY), 0);
    S_VALID = 1'b0;
    WRST_n  = 1'b0;
    tick();
    check("mid_rst_ready", 32'(S_READY), 0);
    check("mid_rst_w_en", 32'(W_EN), 0);
    check("mid_rst_w_data", 32'(W_DATA), 0);
    WRST_n = 1'b1;
    FULL   = 1'b0;
    #1;
    check("mid_rel_w_en", 32'(W_EN), 0);
    tick();
    check("mid_rel_ready", 32'(S_READY), 1);
    check("mid_rel_w_en_1", 32'(W_EN), 0);
    tick();
    check("mid_rel_w_en_2", 32'(W_EN), 0);
    check("sb_empty", 32'(sb_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
